// File: rtl/seq_divider.sv
// Sequential signed restoring divider with C semantics and a Run/Ready handshake.
// Optional debug ports State/Counter when DIVIDER_DEBUG_EN is defined.
module seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Run,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Ready,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivZero,
    output logic             Overflow
`ifdef DIVIDER_DEBUG_EN
    ,
    output logic [2:0]              State,
    output logic [$clog2(WIDTH):0]  Counter
`endif
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StCalc = 3'd2,
        StFix  = 3'd3,
        StDone = 3'd4
    } state_e;

    state_e           state_q;
    logic             ready_q;
    logic             load_ph_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sign_a_q, sign_b_q;
    logic [WIDTH-1:0] mag_a_q, mag_b_q;
    logic [WIDTH:0]   pr_q;
    logic [WIDTH-1:0] q_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH+1:0] pr_shift;
    logic [WIDTH+1:0] trial;

    always_comb begin
        pr_shift = {pr_q, q_q[WIDTH-1]};
        trial    = pr_shift - {2'b00, mag_b_q};
    end

    // LOAD spans two cycles: magnitudes are registered first, then the
    // zero-divisor decision and iteration setup use those registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= StIdle;
            ready_q   <= 1'b1;
            load_ph_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            pr_q      <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            DivZero   <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (Run) begin
                        a_q       <= A;
                        b_q       <= B;
                        load_ph_q <= 1'b0;
                        ready_q   <= 1'b0;
                        state_q   <= StLoad;
                    end
                end
                StLoad: begin
                    if (!load_ph_q) begin
                        sign_a_q  <= a_q[WIDTH-1];
                        sign_b_q  <= b_q[WIDTH-1];
                        mag_a_q   <= a_q[WIDTH-1] ? -a_q : a_q;
                        mag_b_q   <= b_q[WIDTH-1] ? -b_q : b_q;
                        DivZero   <= 1'b0;
                        Overflow  <= 1'b0;
                        load_ph_q <= 1'b1;
                    end else begin
                        pr_q      <= '0;
                        q_q       <= mag_a_q;
                        cnt_q     <= CW'(WIDTH);
                        load_ph_q <= 1'b0;
                        if (mag_b_q == '0) begin
                            Quotient  <= '1;
                            Remainder <= a_q;
                            DivZero   <= 1'b1;
                            ready_q   <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    pr_q  <= trial[WIDTH+1] ? pr_shift[WIDTH:0] : trial[WIDTH:0];
                    q_q   <= {q_q[WIDTH-2:0], ~trial[WIDTH+1]};
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    Quotient  <= (sign_a_q ^ sign_b_q) ? -q_q : q_q;
                    Remainder <= sign_a_q ? -pr_q[WIDTH-1:0] : pr_q[WIDTH-1:0];
                    Overflow  <= (a_q == MinVal) && (b_q == '1);
                    ready_q   <= 1'b1;
                    state_q   <= StDone;
                end
                StDone: begin
                    if (!Run) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign Ready = ready_q;

`ifdef DIVIDER_DEBUG_EN
    assign State   = state_q;
    assign Counter = cnt_q;
`endif

endmodule
